// File: rtl/rtc_bus_controller_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_controller_if
//   Multiplexed address/data bus to the external RTC chip.
//
//   Signals
//     ad_in   8  data returned by the RTC during a read-data cycle
//     ad_out  8  address or data driven towards the RTC
//     ad_oe   1  1 = controller drives the bus (pad tristate lives at top level)
//     cs_n    1  chip select, active-low
//     rd_n    1  read strobe, active-low
//     wr_n    1  write strobe, active-low
//     a_d     1  phase select, 0 = address phase, 1 = data phase
//
//   Modports
//     master  the bus-cycle engine (drives strobes, samples ad_in)
//     slave   the RTC side (drives ad_in, observes strobes)
// ---------------------------------------------------------------------------
interface rtc_bus_controller_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );
endinterface

// File: rtl/rtc_bus_controller.sv
// ---------------------------------------------------------------------------
// rtc_bus_controller
//   Bus-cycle engine between the PicoBlaze register bank and the RTC chip.
//   A write sequence pushes the nine time/date/timer bytes to the RTC and
//   then issues the 0xF1 "RAM to clock" command. A read sequence issues the
//   0xF0 "clock to RAM" command and then reads the nine registers back into
//   the *le holding registers.
//
//   Parameters
//     T_PH            cycles per bus half-phase (strobe-active or recovery), 1..15
//
//   Ports
//     clk, reset      clock, asynchronous active-high reset
//     escribir, leer  single-cycle write / read requests
//     ano..st         bytes to write (BCD) from the register bank
//     bus             RTC bus (master modport)
//     anole..stle     bytes read back from the RTC
//     Listo_es        one-cycle pulse when a write sequence completes
//     Listo_le        one-cycle pulse when a read sequence completes
//     busy            high from request acceptance through the done pulse
//     o_dbg_state     current FSM state
//
//   Request handshake: escribir/leer are sampled on every rising edge. In
//   IDLE a request is accepted on that edge, the strobes go low and busy
//   rises in the following cycle. escribir has priority; a leer seen
//   together with escribir, or while busy, is held as a single pending read
//   that starts from the IDLE cycle following DONE. escribir while busy is
//   dropped. Completion is signalled by Listo_es / Listo_le during DONE.
// ---------------------------------------------------------------------------
module rtc_bus_controller #(
    parameter int T_PH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 escribir,
    input  logic                 leer,
    input  logic [7:0]           ano,
    input  logic [7:0]           mes,
    input  logic [7:0]           dia,
    input  logic [7:0]           horas,
    input  logic [7:0]           minutos,
    input  logic [7:0]           segundos,
    input  logic [7:0]           ht,
    input  logic [7:0]           mt,
    input  logic [7:0]           st,
    rtc_bus_controller_if.master bus,
    output logic [7:0]           anole,
    output logic [7:0]           mesle,
    output logic [7:0]           diale,
    output logic [7:0]           horasle,
    output logic [7:0]           minutosle,
    output logic [7:0]           segundosle,
    output logic [7:0]           htle,
    output logic [7:0]           mtle,
    output logic [7:0]           stle,
    output logic                 Listo_es,
    output logic                 Listo_le,
    output logic                 busy,
    output logic [2:0]           o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_ACT = 3'd1,
        ADDR_REC = 3'd2,
        WR_ACT   = 3'd3,
        WR_REC   = 3'd4,
        RD_ACT   = 3'd5,
        RD_REC   = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [3:0] LP_PH_LAST  = 4'(T_PH - 1);
    localparam logic [3:0] LP_IDX_LAST = 4'd8;
    // Index slot used for the 0xF0 / 0xF1 command cycle.
    localparam logic [3:0] LP_IDX_CMD  = 4'd9;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_phase;
    logic [3:0] w_phase_nxt;
    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;
    logic       r_wr_mode;
    logic       w_wr_mode_nxt;
    logic       r_pending;
    logic       w_pending_nxt;
    logic       w_accept_wr;
    logic       w_phase_end;
    logic       w_sample_rd;

    logic [7:0] r_snap [9];
    logic [7:0] r_le   [9];

    logic [7:0] r_ad_out;
    logic       r_ad_oe;
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_a_d;
    logic       r_listo_es;
    logic       r_listo_le;
    logic       r_busy;

    logic [7:0] w_ad_out_nxt;
    logic       w_ad_oe_nxt;
    logic       w_cs_n_nxt;
    logic       w_rd_n_nxt;
    logic       w_wr_n_nxt;
    logic       w_a_d_nxt;

    // RTC register address for index k; the command slot depends on direction.
    function automatic logic [7:0] reg_addr(input logic [3:0] idx, input logic wr_mode);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h43;
            default: a = wr_mode ? 8'hF1 : 8'hF0;
        endcase
        return a;
    endfunction

    assign w_phase_end = (r_phase == LP_PH_LAST);
    assign w_sample_rd = (r_state == RD_ACT) && w_phase_end;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_idx_nxt     = r_idx;
        w_wr_mode_nxt = r_wr_mode;
        w_pending_nxt = r_pending;
        w_accept_wr   = 1'b0;

        if (r_state != IDLE && leer) begin
            w_pending_nxt = 1'b1;
        end

        unique case (r_state)
            IDLE: begin
                w_phase_nxt = 4'd0;
                if (escribir) begin
                    w_state_nxt   = ADDR_ACT;
                    w_idx_nxt     = 4'd0;
                    w_wr_mode_nxt = 1'b1;
                    w_accept_wr   = 1'b1;
                    w_pending_nxt = r_pending | leer;
                end else if (leer || r_pending) begin
                    // Reads open with the 0xF0 command before the data slots.
                    w_state_nxt   = ADDR_ACT;
                    w_idx_nxt     = LP_IDX_CMD;
                    w_wr_mode_nxt = 1'b0;
                    w_pending_nxt = 1'b0;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_phase_nxt = 4'd0;
            end
            default: begin
                if (w_phase_end) begin
                    w_phase_nxt = 4'd0;
                    case (r_state)
                        ADDR_ACT: w_state_nxt = ADDR_REC;
                        ADDR_REC: begin
                            if (r_idx == LP_IDX_CMD) begin
                                if (r_wr_mode) begin
                                    w_state_nxt = DONE;
                                end else begin
                                    w_state_nxt = ADDR_ACT;
                                    w_idx_nxt   = 4'd0;
                                end
                            end else begin
                                w_state_nxt = r_wr_mode ? WR_ACT : RD_ACT;
                            end
                        end
                        WR_ACT: w_state_nxt = WR_REC;
                        WR_REC: begin
                            // Writes close with the 0xF1 command after slot 8.
                            w_state_nxt = ADDR_ACT;
                            w_idx_nxt   = (r_idx == LP_IDX_LAST) ? LP_IDX_CMD : r_idx + 4'd1;
                        end
                        RD_ACT: w_state_nxt = RD_REC;
                        RD_REC: begin
                            if (r_idx == LP_IDX_LAST) begin
                                w_state_nxt = DONE;
                            end else begin
                                w_state_nxt = ADDR_ACT;
                                w_idx_nxt   = r_idx + 4'd1;
                            end
                        end
                        default: w_state_nxt = IDLE;
                    endcase
                end else begin
                    w_phase_nxt = r_phase + 4'd1;
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bus outputs decoded from the next state so they come straight off flops
    // and line up with the state they belong to.
    // -----------------------------------------------------------------------
    always_comb begin
        w_ad_out_nxt = 8'h00;
        w_ad_oe_nxt  = 1'b0;
        w_cs_n_nxt   = 1'b1;
        w_rd_n_nxt   = 1'b1;
        w_wr_n_nxt   = 1'b1;
        w_a_d_nxt    = 1'b1;

        unique case (w_state_nxt)
            ADDR_ACT, ADDR_REC: begin
                w_a_d_nxt    = 1'b0;
                w_ad_oe_nxt  = 1'b1;
                w_ad_out_nxt = reg_addr(w_idx_nxt, w_wr_mode_nxt);
                if (w_state_nxt == ADDR_ACT) begin
                    w_cs_n_nxt = 1'b0;
                    w_wr_n_nxt = 1'b0;
                end
            end
            WR_ACT, WR_REC: begin
                w_ad_oe_nxt  = 1'b1;
                w_ad_out_nxt = r_snap[w_idx_nxt];
                if (w_state_nxt == WR_ACT) begin
                    w_cs_n_nxt = 1'b0;
                    w_wr_n_nxt = 1'b0;
                end
            end
            RD_ACT: begin
                w_cs_n_nxt = 1'b0;
                w_rd_n_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, counters and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_phase    <= 4'd0;
            r_idx      <= 4'd0;
            r_wr_mode  <= 1'b0;
            r_pending  <= 1'b0;
            r_ad_out   <= 8'h00;
            r_ad_oe    <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_a_d      <= 1'b1;
            r_listo_es <= 1'b0;
            r_listo_le <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_idx      <= w_idx_nxt;
            r_wr_mode  <= w_wr_mode_nxt;
            r_pending  <= w_pending_nxt;
            r_ad_out   <= w_ad_out_nxt;
            r_ad_oe    <= w_ad_oe_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_rd_n     <= w_rd_n_nxt;
            r_wr_n     <= w_wr_n_nxt;
            r_a_d      <= w_a_d_nxt;
            r_listo_es <= (w_state_nxt == DONE) && w_wr_mode_nxt;
            r_listo_le <= (w_state_nxt == DONE) && !w_wr_mode_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    // Write snapshot, in bus order k = 0..8.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                r_snap[i] <= 8'h00;
            end
        end else if (w_accept_wr) begin
            r_snap[0] <= segundos;
            r_snap[1] <= minutos;
            r_snap[2] <= horas;
            r_snap[3] <= dia;
            r_snap[4] <= mes;
            r_snap[5] <= ano;
            r_snap[6] <= st;
            r_snap[7] <= mt;
            r_snap[8] <= ht;
        end
    end

    // Read-back holding registers; ad_in is captured on the last RD_ACT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                r_le[i] <= 8'h00;
            end
        end else if (w_sample_rd) begin
            r_le[r_idx] <= bus.ad_in;
        end
    end

    assign bus.ad_out  = r_ad_out;
    assign bus.ad_oe   = r_ad_oe;
    assign bus.cs_n    = r_cs_n;
    assign bus.rd_n    = r_rd_n;
    assign bus.wr_n    = r_wr_n;
    assign bus.a_d     = r_a_d;

    assign segundosle  = r_le[0];
    assign minutosle   = r_le[1];
    assign horasle     = r_le[2];
    assign diale       = r_le[3];
    assign mesle       = r_le[4];
    assign anole       = r_le[5];
    assign stle        = r_le[6];
    assign mtle        = r_le[7];
    assign htle        = r_le[8];

    assign Listo_es    = r_listo_es;
    assign Listo_le    = r_listo_le;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rtc_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_controller
//   Drives write/read requests, models the RTC register file, and checks the
//   observed bus events, done pulses and read-back values against an ordered
//   expectation queue built from the register map and sequence rules.
// ---------------------------------------------------------------------------
module tb_rtc_bus_controller;

    localparam int T_PH = 4;
    // First bus cycle to done pulse: 9 * 4*T_PH + 2*T_PH.
    localparam int LAT  = 38 * T_PH;

    // Event encoding pushed to exp_q: {kind, byte}
    //   kind 0 = address cycle (byte = address)
    //   kind 1 = write-data cycle (byte = data)
    //   kind 2 = read-data cycle (byte = address being read)
    localparam logic [1:0] EV_ADDR = 2'd0;
    localparam logic [1:0] EV_WDAT = 2'd1;
    localparam logic [1:0] EV_RDAT = 2'd2;
    localparam logic [1:0] EV_BAD  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic       escribir, leer;
    logic [7:0] ano, mes, dia, horas, minutos, segundos, ht, mt, st;
    logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle;
    logic       Listo_es, Listo_le, busy;
    logic [2:0] dbg_state;

    rtc_bus_controller_if bus_if ();

    rtc_bus_controller #(.T_PH(T_PH)) dut (
        .clk        (clk),
        .reset      (reset),
        .escribir   (escribir),
        .leer       (leer),
        .ano        (ano),
        .mes        (mes),
        .dia        (dia),
        .horas      (horas),
        .minutos    (minutos),
        .segundos   (segundos),
        .ht         (ht),
        .mt         (mt),
        .st         (st),
        .bus        (bus_if.master),
        .anole      (anole),
        .mesle      (mesle),
        .diale      (diale),
        .horasle    (horasle),
        .minutosle  (minutosle),
        .segundosle (segundosle),
        .htle       (htle),
        .mtle       (mtle),
        .stle       (stle),
        .Listo_es   (Listo_es),
        .Listo_le   (Listo_le),
        .busy       (busy),
        .o_dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    logic [7:0] addr_tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] wval [9];       // values to write, bus order
    logic [7:0] rtc_mem [256];  // RTC register file seen by reads
    logic [7:0] cur_addr = 8'h00;

    assign bus_if.ad_in = rtc_mem[cur_addr];

    logic [9:0]  exp_q [$];
    logic [33:0] exp_done_q [$];   // {kind (1 = es, 2 = le), cycle}

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=none (cycle %0d)", name, act, cyc);
    endtask

    function automatic logic [7:0] le_val(input int k);
        case (k)
            0:       return segundosle;
            1:       return minutosle;
            2:       return horasle;
            3:       return diale;
            4:       return mesle;
            5:       return anole;
            6:       return stle;
            7:       return mtle;
            default: return htle;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_inputs();
        segundos = wval[0]; minutos = wval[1]; horas = wval[2];
        dia      = wval[3]; mes     = wval[4]; ano   = wval[5];
        st       = wval[6]; mt      = wval[7]; ht    = wval[8];
    endtask

    task automatic push_write_exp(input int t);
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back({EV_ADDR, addr_tbl[k]});
            exp_q.push_back({EV_WDAT, wval[k]});
        end
        exp_q.push_back({EV_ADDR, 8'hF1});
        exp_done_q.push_back({2'd1, 32'(t + LAT)});
    endtask

    task automatic push_read_exp(input int t);
        exp_q.push_back({EV_ADDR, 8'hF0});
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back({EV_ADDR, addr_tbl[k]});
            exp_q.push_back({EV_RDAT, addr_tbl[k]});
        end
        exp_done_q.push_back({2'd2, 32'(t + LAT)});
    endtask

    // Issues a request from IDLE. t = cycle count at which the first bus
    // cycle is visible. A read queued behind a write starts one IDLE cycle
    // after the write's done pulse.
    task automatic start(input bit w, input bit r, input bit pend_rd, output int t);
        @(negedge clk);
        t = cyc + 1;
        if (w) push_write_exp(t);
        if (w && (r || pend_rd)) push_read_exp(t + LAT + 2);
        else if (!w && r) push_read_exp(t);
        escribir = w;
        leer     = r;
        @(negedge clk);
        escribir = 1'b0;
        leer     = 1'b0;
    endtask

    task automatic pulse_only(input bit w, input bit r);
        @(negedge clk);
        escribir = w;
        leer     = r;
        @(negedge clk);
        escribir = 1'b0;
        leer     = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || exp_done_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_drain_left", tag), 32'(exp_q.size() + exp_done_q.size()), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_le(input string tag);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s_le%0d", tag, k), 32'(le_val(k)), 32'(rtc_mem[addr_tbl[k]]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk($sformatf("%s_cs_n", tag),  32'(bus_if.cs_n),   32'd1);
        chk($sformatf("%s_rd_n", tag),  32'(bus_if.rd_n),   32'd1);
        chk($sformatf("%s_wr_n", tag),  32'(bus_if.wr_n),   32'd1);
        chk($sformatf("%s_a_d", tag),   32'(bus_if.a_d),    32'd1);
        chk($sformatf("%s_ad_oe", tag), 32'(bus_if.ad_oe),  32'd0);
        chk($sformatf("%s_ad_out", tag),32'(bus_if.ad_out), 32'd0);
        chk($sformatf("%s_busy", tag),  32'(busy),          32'd0);
        chk($sformatf("%s_listo", tag), 32'({Listo_es, Listo_le}), 32'd0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s_le%0d", tag, k), 32'(le_val(k)), 32'd0);
        end
    endtask

    // Asserts reset between edges and checks outputs before the next edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #($urandom_range(1, 3));
        reset = 1'b1;
        exp_q.delete();
        exp_done_q.delete();
        #1;
        check_reset_vals(tag);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic randomize_wval();
        for (int k = 0; k < 9; k++) wval[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic randomize_rtc();
        for (int k = 0; k < 9; k++) rtc_mem[addr_tbl[k]] = 8'($urandom_range(0, 255));
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         in_span = 0;
    bit         have_prev = 0;
    int         span_len = 0;
    int         gap = 0;
    bit         unstable = 0;
    logic [7:0] s_out;
    logic       s_ad;
    logic       s_oe;

    always @(negedge clk) begin
        logic [9:0]  ev;
        logic [9:0]  e;
        logic [33:0] d;
        if (reset) begin
            in_span   = 0;
            have_prev = 0;
            gap       = 0;
        end else begin
            if (!bus_if.rd_n || !bus_if.wr_n)
                chk("strobe_overlap", 32'(!bus_if.rd_n && !bus_if.wr_n), 32'd0);
            if (!bus_if.rd_n)
                chk("oe_during_read", 32'(bus_if.ad_oe), 32'd0);

            if (!bus_if.cs_n) begin
                if (!in_span) begin
                    if (have_prev) chk("cs_gap_ge_tph", 32'(gap >= T_PH), 32'd1);
                    in_span  = 1;
                    span_len = 1;
                    unstable = 0;
                    s_out    = bus_if.ad_out;
                    s_ad     = bus_if.a_d;
                    s_oe     = bus_if.ad_oe;
                    if (!bus_if.rd_n) begin
                        ev = {EV_RDAT, cur_addr};
                    end else if (!bus_if.wr_n && !bus_if.a_d) begin
                        ev = {EV_ADDR, bus_if.ad_out};
                        cur_addr = bus_if.ad_out;
                    end else if (!bus_if.wr_n) begin
                        ev = {EV_WDAT, bus_if.ad_out};
                    end else begin
                        ev = {EV_BAD, bus_if.ad_out};
                    end
                    if (exp_q.size() == 0) begin
                        unexpected("bus_event", 32'(ev));
                    end else begin
                        e = exp_q.pop_front();
                        chk("bus_event", 32'(ev), 32'(e));
                    end
                end else begin
                    span_len++;
                    if (bus_if.a_d !== s_ad || (s_oe && bus_if.ad_out !== s_out)) unstable = 1;
                end
            end else begin
                if (in_span) begin
                    chk("cs_low_len", 32'(span_len), 32'(T_PH));
                    in_span   = 0;
                    have_prev = 1;
                    gap       = 1;
                end else begin
                    gap++;
                end
                if (have_prev && gap <= T_PH) begin
                    if (bus_if.a_d !== s_ad || (s_oe && bus_if.ad_out !== s_out)) unstable = 1;
                    if (gap == T_PH) chk("cycle_stable", 32'(unstable), 32'd0);
                end
            end

            if (Listo_es || Listo_le) begin
                if (exp_done_q.size() == 0) begin
                    unexpected("done_pulse", 32'({Listo_le, Listo_es}));
                end else begin
                    d = exp_done_q.pop_front();
                    chk("done_kind", 32'({Listo_le, Listo_es}), 32'(d[33:32]));
                    chk("done_cycle", 32'(cyc), d[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int off;
        reset    = 1'b1;
        escribir = 1'b0;
        leer     = 1'b0;
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'(i ^ 8'h5A);
        for (int k = 0; k < 9; k++) wval[k] = 8'h00;
        apply_inputs();

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("rst_init");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Read with known RTC contents
        for (int k = 0; k < 6; k++) rtc_mem[addr_tbl[k]] = 8'(8'h60 + 8'h11 * k);
        rtc_mem[8'h41] = 8'h57;
        rtc_mem[8'h42] = 8'h40;
        rtc_mem[8'h43] = 8'h23;
        start(1'b0, 1'b1, 1'b0, t);
        chk("rd_busy_rise", 32'(busy), 32'd1);
        drain("read1");
        chk("stle", 32'(stle), 32'h57);
        chk("mtle", 32'(mtle), 32'h40);
        chk("htle", 32'(htle), 32'h23);
        check_le("read1");

        // Reset while idle clears the read-back registers
        async_reset("rst_idle");
        repeat (3) @(negedge clk);

        // Write with the reference values, inputs disturbed mid-sequence
        wval = '{8'h43, 8'h29, 8'h15, 8'h01, 8'h02, 8'h13, 8'h57, 8'h40, 8'h23};
        apply_inputs();
        start(1'b1, 1'b0, 1'b0, t);
        chk("wr_busy_rise", 32'(busy), 32'd1);
        wait_until(t + $urandom_range(10, 120));
        {segundos, minutos, horas, dia, mes, ano, st, mt, ht} = {$urandom, $urandom, $urandom};
        drain("write1");

        // Reset mid-write with a read pending: nothing may follow
        randomize_wval();
        apply_inputs();
        start(1'b1, 1'b0, 1'b0, t);
        wait_until(t + $urandom_range(5, 60));
        pulse_only(1'b0, 1'b1);
        wait_until(t + $urandom_range(70, 140));
        async_reset("rst_mid_write");
        repeat (2 * LAT) @(negedge clk);

        // Random writes and reads
        for (int i = 0; i < 2; i++) begin
            randomize_wval();
            apply_inputs();
            start(1'b1, 1'b0, 1'b0, t);
            drain("rnd_write");
            randomize_rtc();
            start(1'b0, 1'b1, 1'b0, t);
            drain("rnd_read");
            check_le("rnd_read");
        end

        // Simultaneous requests: write, one IDLE cycle, then read
        randomize_wval();
        apply_inputs();
        randomize_rtc();
        start(1'b1, 1'b1, 1'b0, t);
        wait_until(t + LAT);
        chk("sim_busy_done", 32'(busy), 32'd1);
        wait_until(t + LAT + 1);
        chk("sim_busy_gap", 32'(busy), 32'd0);
        wait_until(t + LAT + 2);
        chk("sim_busy_read", 32'(busy), 32'd1);
        drain("simul");
        check_le("simul");

        // escribir during a read is ignored
        randomize_rtc();
        start(1'b0, 1'b1, 1'b0, t);
        wait_until(t + $urandom_range(10, 140));
        pulse_only(1'b1, 1'b0);
        drain("wr_during_rd");
        repeat (60) @(negedge clk);
        check_le("wr_during_rd");

        // Two leer pulses during a write give one read afterwards
        randomize_wval();
        apply_inputs();
        randomize_rtc();
        start(1'b1, 1'b0, 1'b1, t);
        off = $urandom_range(5, 60);
        wait_until(t + off);
        pulse_only(1'b0, 1'b1);
        wait_until(t + off + $urandom_range(10, 70));
        pulse_only(1'b0, 1'b1);
        drain("rd_twice");
        repeat (2 * LAT) @(negedge clk);
        check_le("rd_twice");

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_controller.md
# rtc_bus_controller

Bus-cycle engine between the PicoBlaze register bank and the external RTC chip. It takes the nine 8-bit time/date/timer values held by the register bank and writes them to the RTC over a multiplexed address/data bus. It also reads the same nine RTC registers back into holding registers that feed the bank's read-side inputs. It produces the write-done pulse (Listo_es) that the register bank consumes.

## Interface

**Parameters**
- T_PH, default 4: cycles per bus half-phase (strobe-active or recovery). Legal range is 1..15.

**Ports**
- clk, in, 1: system clock. All logic is on the rising edge.
- reset, in, 1: asynchronous, active-high. Forces the reset state immediately.
- escribir, in, 1: single-cycle write-sequence request.
- leer, in, 1: single-cycle read-sequence request.
- ano, mes, dia, horas, minutos, segundos, ht, mt, st, in, 8 each: values to write, BCD, from the register bank.
- ad_in, in, 8: RTC bus data in.
- ad_out, out, 8: RTC bus data out.
- ad_oe, out, 1: bus output enable, 1 = drive. The pad tristate lives at top level.
- cs_n, rd_n, wr_n, out, 1 each: RTC strobes, active-low.
- a_d, out, 1: bus phase select, 0 = address phase, 1 = data phase.
- anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle, out, 8 each: values read back from the RTC.
- Listo_es, out, 1: one-cycle pulse when a write sequence completes.
- Listo_le, out, 1: one-cycle pulse when a read sequence completes.
- busy, out, 1: high from request acceptance until the cycle of the done pulse, inclusive.

## Operation

**Register map and order.** Index k = 0..8 maps to the following RTC addresses:

| k | 0 | 1 | 2 | 3 | 4 | 5 | 6 | 7 | 8 |
|---|---|---|---|---|---|---|---|---|---|
| Register | segundos | minutos | horas | dia | mes | ano | st | mt | ht |
| Address | 0x21 | 0x22 | 0x23 | 0x24 | 0x25 | 0x26 | 0x41 | 0x42 | 0x43 |

**Bus cycle types.** Each half-phase lasts T_PH cycles.
- Address cycle:
  - ACT: a_d = 0, cs_n = 0, wr_n = 0, ad_oe = 1, ad_out = address.
  - REC: cs_n = 1, wr_n = 1; a_d, ad_oe and ad_out are held.
- Write-data cycle: same as the address cycle, but a_d = 1 and ad_out = data.
- Read-data cycle:
  - ACT: a_d = 1, cs_n = 0, rd_n = 0, ad_oe = 0. ad_in is sampled into the target `*le` register on the last ACT cycle.
  - REC: strobes high.

**Write sequence.**
- On acceptance, all nine inputs are snapshotted into internal registers. Later input changes do not affect the sequence in progress.
- For k = 0..8: address cycle, then write-data cycle with snapshot[k].
- Then an address-only cycle with 0xF1 (transfer RAM to clock).
- Then Listo_es = 1 for one cycle.

**Read sequence.**
- First, an address-only cycle with 0xF0 (latch clock into RAM).
- Then, for k = 0..8: address cycle followed by read-data cycle.
- Then Listo_le = 1 for one cycle.
- Each `*le` register updates only on its own sample cycle.

**FSM states.** IDLE, ADDR_ACT, ADDR_REC, WR_ACT, WR_REC, RD_ACT, RD_REC, DONE.
- A 4-bit phase counter runs 0..T_PH-1 within each state. The state advances when the counter reaches T_PH-1.
- A 4-bit index counter selects k. An extra slot represents the command cycle.
- DONE lasts exactly 1 cycle, then returns to IDLE.

**Arbitration.**
- escribir and leer asserted together in IDLE: the write sequence runs. leer is latched as pending.
- leer while busy: latched as pending (one deep). It starts on the cycle after DONE.
- escribir while busy: ignored.

## Timing

**Reset values.**
- cs_n = rd_n = wr_n = 1, a_d = 1.
- ad_oe = 0, ad_out = 0x00.
- All `*le` outputs = 0x00.
- Listo_es = Listo_le = busy = 0.
- Pending flag cleared, FSM in IDLE.

**Request acceptance.**
- A request sampled in IDLE on edge n puts the FSM in ADDR_ACT after edge n, so the strobes go low in cycle n+1.
- busy rises in the same cycle as the strobes.

**Latency.**
- Each address or data cycle takes 2·T_PH cycles.
- Write: 9 × 4·T_PH + 2·T_PH = 38·T_PH cycles of bus activity. Listo_es follows in the next cycle. With T_PH = 4, Listo_es is high in cycle n+153.
- Read: 38·T_PH bus cycles, then Listo_le.

**Strobe and data rules.**
- Strobes never overlap: rd_n and wr_n are never both 0.
- cs_n is 1 for at least T_PH cycles between consecutive ACT phases.
- ad_out and a_d are stable for the whole ACT+REC span of a driven cycle.
- ad_oe falls to 0 no later than the first cycle of RD_ACT.

**Reset mid-operation.**
- All outputs return immediately to their reset values, including the `*le` registers.
- No Listo pulse is produced and the pending request is discarded.

**Pending read after a write.** After Listo_es, a pending read starts with at least one IDLE cycle. busy is 0 for that one cycle.

## Test plan

1. **Reset.** Assert reset mid-idle and then mid-write at an arbitrary phase. Strobes go high and ad_oe goes to 0 asynchronously. All `*le` outputs read 0x00 and busy = 0.
2. **Write.** T_PH = 4. Inputs: ano = 0x13, mes = 0x02, dia = 0x01, horas = 0x15, minutos = 0x29, segundos = 0x43, ht = 0x23, mt = 0x40, st = 0x57. Pulse escribir.
   - Monitor decodes the bus pairs (0x21, 0x43), (0x22, 0x29), … (0x43, 0x23), then address 0xF1.
   - Listo_es pulses for exactly one cycle, 153 cycles after the request.
   - Changing the inputs mid-sequence does not alter the written data.
3. **Read.** The RTC model returns 0x57, 0x40, 0x23 for addresses 0x41, 0x42, 0x43 and distinct values elsewhere. Pulse leer.
   - Address 0xF0 appears first.
   - stle = 0x57, mtle = 0x40, htle = 0x23, and the other outputs match the model.
   - Listo_le pulses once.
4. **Simultaneous requests.** escribir and leer asserted together: the full write completes, one IDLE cycle follows, then the read runs. Exactly one Listo_es and one Listo_le are produced.
5. **Busy handling.** escribir pulsed during a read is ignored (no second Listo_es). leer pulsed twice during a write gives exactly one read afterwards.
6. **Bus protocol checker, across all scenarios.**
   - rd_n and wr_n are never both 0.
   - ad_oe = 0 whenever rd_n = 0.
   - Each cs_n-low span is exactly T_PH cycles, with a gap of at least T_PH cycles.
